// File: rtl/acc_seq_if.sv
// Command/response handshake bundle between a host and the accumulator sequencer.
interface acc_seq_if #(parameter int W = 4);
  logic         cmd_valid;
  logic         cmd_ready;
  logic [3:0]   cmd_op;
  logic [W-1:0] cmd_data;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [W-1:0] rsp_data;

  modport master (output cmd_valid, cmd_op, cmd_data, rsp_ready,
                  input  cmd_ready, rsp_valid, rsp_data);
  modport slave  (input  cmd_valid, cmd_op, cmd_data, rsp_ready,
                  output cmd_ready, rsp_valid, rsp_data);
endinterface

// File: rtl/acc_sequencer.sv
// Sequencer driving an external alu + register pair as an accumulator, one command at a time.
// Optional ACC_SEQ_ZFLAG_EN adds rsp_zero (accumulator == 0, qualified by rsp_valid).
module acc_sequencer #(
  parameter int W   = 4,
  parameter int OCW = 3
) (
  input  logic           clk,
  input  logic           rst_n,
  acc_seq_if.slave       bus,
  output logic [OCW-1:0] alu_oc,
  output logic [W-1:0]   alu_a,
  output logic [W-1:0]   alu_b,
  input  logic [W-1:0]   alu_f,
  output logic           reg_cl,
  output logic           reg_ld,
  output logic           reg_inc,
  output logic           reg_dec,
  output logic           reg_sr,
  output logic           reg_ir,
  output logic           reg_sl,
  output logic           reg_il,
  output logic [W-1:0]   reg_in,
  input  logic [W-1:0]   reg_out
`ifdef ACC_SEQ_ZFLAG_EN
  ,
  output logic           rsp_zero
`endif
);
  typedef enum logic [1:0] {IDLE, EXEC, WB, RESP} state_t;

  state_t       r_state, w_next;
  logic [3:0]   r_op;
  logic [W-1:0] r_data;
  logic [W-1:0] r_res;
  logic         w_accept;

  assign w_accept = (r_state == IDLE) && bus.cmd_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_op    <= '0;
      r_data  <= '0;
      r_res   <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_op   <= bus.cmd_op;
        r_data <= bus.cmd_data;
      end
      if (r_state == EXEC && !r_op[3]) r_res <= alu_f;
    end
  end

  // Strobes decode from registered state only, so async reset kills them at once.
  always_comb begin
    w_next  = r_state;
    reg_cl  = 1'b0;
    reg_ld  = 1'b0;
    reg_inc = 1'b0;
    reg_dec = 1'b0;
    reg_sr  = 1'b0;
    reg_ir  = 1'b0;
    reg_sl  = 1'b0;
    reg_il  = 1'b0;
    reg_in  = '0;
    case (r_state)
      IDLE: if (w_accept) w_next = EXEC;
      EXEC: begin
        if (r_op[3]) begin
          w_next = RESP;
          case (r_op[2:0])
            3'd0: reg_cl = 1'b1;
            3'd1: begin reg_ld = 1'b1; reg_in = r_data; end
            3'd2: reg_inc = 1'b1;
            3'd3: reg_dec = 1'b1;
            3'd4: begin reg_sr = 1'b1; reg_ir = r_data[0]; end
            3'd5: begin reg_sl = 1'b1; reg_il = r_data[0]; end
            default: ;
          endcase
        end else begin
          w_next = WB;
        end
      end
      WB: begin
        reg_ld = 1'b1;
        reg_in = r_res;
        w_next = RESP;
      end
      RESP: if (bus.rsp_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  assign bus.cmd_ready = (r_state == IDLE);
  assign bus.rsp_valid = (r_state == RESP);
  assign bus.rsp_data  = (r_state == RESP) ? reg_out : '0;

  assign alu_oc = r_op[OCW-1:0];
  assign alu_a  = reg_out;
  assign alu_b  = r_data;

`ifdef ACC_SEQ_ZFLAG_EN
  assign rsp_zero = (r_state == RESP) && (reg_out == '0);
`endif
endmodule

// File: tb/tb_acc_sequencer.sv
// Randomized self-checking bench for acc_sequencer with behavioural alu/register and accumulator model.
module tb_acc_sequencer;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] alu_oc;
  logic [3:0] alu_a, alu_b, alu_f, reg_in, reg_out;
  logic       reg_cl, reg_ld, reg_inc, reg_dec, reg_sr, reg_ir, reg_sl, reg_il;
`ifdef ACC_SEQ_ZFLAG_EN
  logic       rsp_zero;
`endif
  logic [3:0] m_reg = 4'd0;
  logic [3:0] exp_acc = 4'd0;
  int         n_chk = 0;
  int         n_fail = 0;

  always #5 clk = ~clk;

  acc_seq_if #(.W(4)) bus ();

  acc_sequencer #(.W(4), .OCW(3)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .alu_oc(alu_oc), .alu_a(alu_a), .alu_b(alu_b), .alu_f(alu_f),
    .reg_cl(reg_cl), .reg_ld(reg_ld), .reg_inc(reg_inc), .reg_dec(reg_dec),
    .reg_sr(reg_sr), .reg_ir(reg_ir), .reg_sl(reg_sl), .reg_il(reg_il),
    .reg_in(reg_in), .reg_out(reg_out)
`ifdef ACC_SEQ_ZFLAG_EN
    , .rsp_zero(rsp_zero)
`endif
  );

  function automatic logic [3:0] alu_fn(input logic [2:0] oc, input logic [3:0] a, input logic [3:0] b);
    int r;
    case (oc)
      3'd0: r = a + b;
      3'd1: r = a - b;
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: r = ~a;
      3'd6: r = ~(a & b);
      default: r = b;
    endcase
    return 4'(r & 15);
  endfunction

  // Environment: combinational alu and a plain 4-bit register.
  assign alu_f   = alu_fn(alu_oc, alu_a, alu_b);
  assign reg_out = m_reg;
  always @(posedge clk) begin
    if (reg_cl)       m_reg <= 4'd0;
    else if (reg_ld)  m_reg <= reg_in;
    else if (reg_inc) m_reg <= m_reg + 4'd1;
    else if (reg_dec) m_reg <= m_reg - 4'd1;
    else if (reg_sr)  m_reg <= {reg_ir, m_reg[3:1]};
    else if (reg_sl)  m_reg <= {m_reg[2:0], reg_il};
  end

  function automatic logic [3:0] ref_next(input logic [3:0] op, input logic [3:0] d, input logic [3:0] acc);
    int a, r;
    a = acc;
    case (op)
      4'd8:  r = 0;
      4'd9:  r = d;
      4'd10: r = (a + 1) % 16;
      4'd11: r = (a + 15) % 16;
      4'd12: r = (a / 2) + (d[0] ? 8 : 0);
      4'd13: r = ((a * 2) + (d[0] ? 1 : 0)) % 16;
      4'd14, 4'd15: r = a;
      default: r = alu_fn(op[2:0], acc, d);
    endcase
    return 4'(r);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [7:0] strobes();
    return {reg_cl, reg_ld, reg_inc, reg_dec, reg_sr, reg_ir, reg_sl, reg_il};
  endfunction

  always @(negedge clk) if (rst_n) begin
    chk("onehot", 32'($countones({reg_cl, reg_ld, reg_inc, reg_dec, reg_sr, reg_sl}) <= 1), 1);
    chk("ir_qual", 32'(reg_ir & ~reg_sr), 0);
    chk("il_qual", 32'(reg_il & ~reg_sl), 0);
    chk("in_qual", reg_ld ? 32'd0 : 32'(reg_in), 0);
`ifdef ACC_SEQ_ZFLAG_EN
    chk("zero_qual", 32'(rsp_zero & ~bus.rsp_valid), 0);
`endif
  end

  task automatic do_cmd(input logic [3:0] op, input logic [3:0] d, input int hold);
    logic [3:0] exp;
    int lat;
    exp = ref_next(op, d, exp_acc);
    bus.cmd_op = op; bus.cmd_data = d; bus.cmd_valid = 1'b1;
    chk("cmd_ready", 32'(bus.cmd_ready), 1);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    lat = 1;
    if (!op[3]) begin
      chk("exec_oc", 32'(alu_oc), 32'(op[2:0]));
      chk("exec_a", 32'(alu_a), 32'(exp_acc));
      chk("exec_b", 32'(alu_b), 32'(d));
      chk("exec_nostrb", 32'(strobes()), 0);
    end else begin
      case (op)
        4'd8:  chk("strb_cl", 32'(strobes()), 32'h80);
        4'd9:  begin chk("strb_ld", 32'(strobes()), 32'h40); chk("ld_in", 32'(reg_in), 32'(d)); end
        4'd10: chk("strb_inc", 32'(strobes()), 32'h20);
        4'd11: chk("strb_dec", 32'(strobes()), 32'h10);
        4'd12: chk("strb_sr", 32'(strobes()), d[0] ? 32'h0C : 32'h08);
        4'd13: chk("strb_sl", 32'(strobes()), d[0] ? 32'h03 : 32'h02);
        default: chk("strb_none", 32'(strobes()), 0);
      endcase
    end
    chk("busy", 32'(bus.cmd_ready), 0);
    if (!op[3]) begin
      @(posedge clk); #1; lat++;
      chk("wb_ld", 32'(reg_ld), 1);
      chk("wb_in", 32'(reg_in), 32'(exp));
    end
    while (!bus.rsp_valid && lat < 10) begin
      @(posedge clk); #1; lat++;
    end
    chk("latency", 32'(lat), op[3] ? 32'd2 : 32'd3);
    chk("rsp_data", 32'(bus.rsp_data), 32'(exp));
`ifdef ACC_SEQ_ZFLAG_EN
    chk("rsp_zero", 32'(rsp_zero), 32'(exp == 4'd0));
`endif
    for (int i = 0; i < hold; i++) begin
      bus.cmd_op = 4'd8; bus.cmd_valid = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      chk("hold_valid", 32'(bus.rsp_valid), 1);
      chk("hold_data", 32'(bus.rsp_data), 32'(exp));
      chk("hold_busy", 32'(bus.cmd_ready), 0);
      chk("hold_nostrb", 32'(strobes()), 0);
    end
    bus.cmd_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    chk("back_idle", 32'(bus.cmd_ready), 1);
    chk("rsp_clear", 32'(bus.rsp_valid), 0);
    chk("acc_reg", 32'(reg_out), 32'(exp));
    exp_acc = exp;
  endtask

  initial begin
    rst_n = 1'b0;
    bus.cmd_valid = 1'b0; bus.cmd_op = 4'd0; bus.cmd_data = 4'd0; bus.rsp_ready = 1'b0;
    repeat (2) @(posedge clk); #1;
    chk("rst_ready", 32'(bus.cmd_ready), 1);
    chk("rst_rspv", 32'(bus.rsp_valid), 0);
    chk("rst_strb", 32'(strobes()), 0);
    chk("rst_alu_b", 32'(alu_b), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    do_cmd(4'd9, 4'b0101, 0);
    for (int k = 0; k < 8; k++) begin
      do_cmd(4'd9, 4'b0101, 0);
      do_cmd(4'(k), 4'b0011, 0);
    end
    do_cmd(4'd9, 4'b0101, 0);
    do_cmd(4'd13, 4'b1001, 0);
    do_cmd(4'd12, 4'b0110, 0);
    do_cmd(4'd15, 4'd0, 5);

    // Reset during the write-back cycle of an alu op.
    do_cmd(4'd9, 4'b0101, 0);
    bus.cmd_op = 4'd0; bus.cmd_data = 4'b0011; bus.cmd_valid = 1'b1;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    @(posedge clk); #1;
    chk("mid_wb_ld", 32'(reg_ld), 1);
    rst_n = 1'b0;
    #1;
    chk("rst_ld_drop", 32'(reg_ld), 0);
    chk("rst_rsp_drop", 32'(bus.rsp_valid), 0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_ready", 32'(bus.cmd_ready), 1);
    chk("post_rst_acc", 32'(reg_out), 32'(exp_acc));
    do_cmd(4'd9, 4'b1010, 0);

    do_cmd(4'd9, 4'b1111, 0);
    do_cmd(4'd10, 4'd0, 0);
    do_cmd(4'd11, 4'd0, 1);

    for (int n = 0; n < 40; n++)
      do_cmd(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), $urandom_range(0, 2));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
